// File: rtl/spi_slave_shifter.sv
// SPI slave data path: synchronises the SCK-control strobes and the SS_n/MOSI
// pins into clk, deserialises MOSI into words, serialises TX words onto MISO
// (MSB first), and exposes a one-entry TX buffer and an RX output register.
module spi_slave_shifter #(
    parameter int                DATA_W  = 8,
    parameter logic [DATA_W-1:0] TX_FILL = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              Shift_clk,
    input  logic              Sample_clk,
    input  logic              SS_n,
    input  logic              MOSI,
    input  logic              CPHA,
    output logic              MISO,
    output logic              idle,
    input  logic [DATA_W-1:0] tx_data,
    input  logic              tx_valid,
    output logic              tx_ready,
    output logic [DATA_W-1:0] rx_data,
    output logic              rx_valid,
    input  logic              rx_ack,
    output logic              overrun,
    output logic              underrun
);

    localparam int              CNT_W    = $clog2(DATA_W + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_W - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    // Bit order of the synchronised input vector: {MOSI, SS_n, Sample_clk, Shift_clk}.
    // SS_n idles high, so its stages come out of reset at 1.
    localparam logic [3:0] SYNC_RST = 4'b0100;

    typedef enum logic {
        ST_IDLE,
        ST_ACTIVE
    } state_t;

    logic [3:0] async_in;
    logic [3:0] sync_s;
    logic [2:0] prev_q;

    assign async_in = {MOSI, SS_n, Sample_clk, Shift_clk};

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_sync
            logic meta_q;
            logic stab_q;

            // Two-flop synchroniser for one asynchronous input.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    meta_q <= SYNC_RST[gi];
                    stab_q <= SYNC_RST[gi];
                end else begin
                    meta_q <= async_in[gi];
                    stab_q <= meta_q;
                end
            end

            assign sync_s[gi] = stab_q;
        end
    endgenerate

    // Delayed copies of the synchronised strobes and SS_n for edge detection.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prev_q <= SYNC_RST[2:0];
        end else begin
            prev_q <= sync_s[2:0];
        end
    end

    logic sh_ev;
    logic sa_ev;
    logic ss_fall;
    logic ss_rise;
    logic mosi_s;

    assign sh_ev   = sync_s[0] & ~prev_q[0];
    assign sa_ev   = sync_s[1] & ~prev_q[1];
    assign ss_fall = prev_q[2] & ~sync_s[2];
    assign ss_rise = ~prev_q[2] & sync_s[2];
    // MOSI goes through the same depth, so it is aligned with sa_ev.
    assign mosi_s  = sync_s[3];

    state_t            state_q, state_d;
    logic [DATA_W-1:0] tx_buf_q, tx_buf_d;
    logic              tx_full_q, tx_full_d;
    logic [DATA_W-1:0] tx_shift_q, tx_shift_d;
    logic [DATA_W-2:0] rx_shift_q, rx_shift_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              first_shift_q, first_shift_d;
    logic              miso_q, miso_d;
    logic [DATA_W-1:0] rx_data_q, rx_data_d;
    logic              rx_valid_q, rx_valid_d;
    logic              overrun_q, overrun_d;
    logic              underrun_q, underrun_d;

    logic [DATA_W-1:0] load_word;
    logic [DATA_W-1:0] rx_word;
    logic              tx_take;

    // Word that goes into the TX shifter at frame start or word boundary.
    assign load_word = tx_full_q ? tx_buf_q : TX_FILL;
    assign rx_word   = {rx_shift_q, mosi_s};

    // Next-state logic: sa_ev is handled before sh_ev so a same-cycle
    // shift sees a freshly reloaded TX word.
    always_comb begin
        state_d       = state_q;
        tx_buf_d      = tx_buf_q;
        tx_full_d     = tx_full_q;
        tx_shift_d    = tx_shift_q;
        rx_shift_d    = rx_shift_q;
        cnt_d         = cnt_q;
        first_shift_d = first_shift_q;
        miso_d        = miso_q;
        rx_data_d     = rx_data_q;
        rx_valid_d    = rx_valid_q;
        overrun_d     = overrun_q;
        underrun_d    = underrun_q;
        tx_take       = 1'b0;

        if (rx_ack) begin
            rx_valid_d = 1'b0;
        end

        case (state_q)
            ST_IDLE: begin
                miso_d = 1'b0;
                if (ss_fall) begin
                    state_d       = ST_ACTIVE;
                    tx_shift_d    = load_word;
                    tx_take       = 1'b1;
                    underrun_d    = underrun_q | ~tx_full_q;
                    cnt_d         = '0;
                    rx_shift_d    = '0;
                    // CPHA=1 waits for the first shift strobe before driving MISO.
                    first_shift_d = CPHA;
                    miso_d        = CPHA ? 1'b0 : load_word[DATA_W-1];
                end
            end

            ST_ACTIVE: begin
                if (ss_rise) begin
                    // Frame aborted or finished: partial words are discarded.
                    state_d       = ST_IDLE;
                    miso_d        = 1'b0;
                    cnt_d         = '0;
                    rx_shift_d    = '0;
                    tx_shift_d    = '0;
                    first_shift_d = 1'b0;
                end else begin
                    if (sa_ev) begin
                        if (cnt_q == CNT_LAST) begin
                            rx_data_d     = rx_word;
                            rx_valid_d    = 1'b1;
                            overrun_d     = overrun_q | (rx_valid_q & ~rx_ack);
                            cnt_d         = '0;
                            rx_shift_d    = '0;
                            tx_shift_d    = load_word;
                            tx_take       = 1'b1;
                            underrun_d    = underrun_q | ~tx_full_q;
                            // Next shift strobe presents the new MSB without shifting.
                            first_shift_d = 1'b1;
                        end else begin
                            rx_shift_d = rx_word[DATA_W-2:0];
                            cnt_d      = cnt_q + CNT_ONE;
                        end
                    end
                    if (sh_ev) begin
                        if (first_shift_d) begin
                            first_shift_d = 1'b0;
                        end else begin
                            tx_shift_d = {tx_shift_d[DATA_W-2:0], 1'b0};
                        end
                        miso_d = tx_shift_d[DATA_W-1];
                    end
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Buffer is vacated first so a same-cycle write can refill it.
        if (tx_take) begin
            tx_full_d = 1'b0;
        end
        if (tx_valid && !tx_full_q) begin
            tx_buf_d  = tx_data;
            tx_full_d = 1'b1;
        end
    end

    // State and data-path registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= ST_IDLE;
            tx_buf_q      <= '0;
            tx_full_q     <= 1'b0;
            tx_shift_q    <= '0;
            rx_shift_q    <= '0;
            cnt_q         <= '0;
            first_shift_q <= 1'b0;
            miso_q        <= 1'b0;
            rx_data_q     <= '0;
            rx_valid_q    <= 1'b0;
            overrun_q     <= 1'b0;
            underrun_q    <= 1'b0;
        end else begin
            state_q       <= state_d;
            tx_buf_q      <= tx_buf_d;
            tx_full_q     <= tx_full_d;
            tx_shift_q    <= tx_shift_d;
            rx_shift_q    <= rx_shift_d;
            cnt_q         <= cnt_d;
            first_shift_q <= first_shift_d;
            miso_q        <= miso_d;
            rx_data_q     <= rx_data_d;
            rx_valid_q    <= rx_valid_d;
            overrun_q     <= overrun_d;
            underrun_q    <= underrun_d;
        end
    end

    assign MISO     = miso_q;
    assign idle     = (state_q == ST_IDLE);
    assign tx_ready = ~tx_full_q;
    assign rx_data  = rx_data_q;
    assign rx_valid = rx_valid_q;
    assign overrun  = overrun_q;
    assign underrun = underrun_q;

endmodule

// File: tb/tb_spi_slave_shifter.sv
// Directed bench for spi_slave_shifter (DATA_W=8, TX_FILL=0): drives the
// strobe levels the SCK control block would produce and checks MISO/RX/status.
module tb_spi_slave_shifter;

    logic       clk;
    logic       rst;
    logic       Shift_clk;
    logic       Sample_clk;
    logic       SS_n;
    logic       MOSI;
    logic       CPHA;
    logic       MISO;
    logic       idle;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_ack;
    logic       overrun;
    logic       underrun;

    int chk_cnt = 0;
    int err_cnt = 0;

    spi_slave_shifter #(
        .DATA_W (8),
        .TX_FILL(8'h00)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .Shift_clk (Shift_clk),
        .Sample_clk(Sample_clk),
        .SS_n      (SS_n),
        .MOSI      (MOSI),
        .CPHA      (CPHA),
        .MISO      (MISO),
        .idle      (idle),
        .tx_data   (tx_data),
        .tx_valid  (tx_valid),
        .tx_ready  (tx_ready),
        .rx_data   (rx_data),
        .rx_valid  (rx_valid),
        .rx_ack    (rx_ack),
        .overrun   (overrun),
        .underrun  (underrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        chk_cnt++;
        if (got !== exp) begin
            err_cnt++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end else begin
            $display("ok   %s: 0x%0h", tag, got);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick(3);
        rst = 1'b0;
        tick(2);
    endtask

    task automatic write_tx(input logic [7:0] d);
        tx_data  = d;
        tx_valid = 1'b1;
        tick(1);
        tx_valid = 1'b0;
        tick(1);
    endtask

    task automatic ack_rx();
        rx_ack = 1'b1;
        tick(1);
        rx_ack = 1'b0;
        tick(1);
    endtask

    task automatic frame_start(input logic c);
        CPHA = c;
        tick(2);
        SS_n = 1'b0;
        tick(6);
    endtask

    task automatic frame_end();
        tick(4);
        SS_n = 1'b1;
        tick(6);
    endtask

    // Clocks nbits bits MSB first; mi collects MISO as a master would sample it.
    task automatic xfer(input logic c, input logic [7:0] mo, input int nbits, output logic [7:0] mi);
        logic b;
        mi = 8'h00;
        for (int i = 0; i < nbits; i++) begin
            b = mo[7-i];
            if (!c) begin
                MOSI = b;
                tick(4);
                mi = {mi[6:0], MISO};
                Sample_clk = 1'b1;
                tick(4);
                Sample_clk = 1'b0;
                Shift_clk  = 1'b1;
                tick(4);
                Shift_clk  = 1'b0;
            end else begin
                Shift_clk = 1'b1;
                MOSI      = b;
                tick(4);
                mi = {mi[6:0], MISO};
                Shift_clk  = 1'b0;
                Sample_clk = 1'b1;
                tick(4);
                Sample_clk = 1'b0;
            end
        end
        tick(4);
    endtask

    logic [7:0] mi;

    initial begin
        rst        = 1'b1;
        Shift_clk  = 1'b0;
        Sample_clk = 1'b0;
        SS_n       = 1'b1;
        MOSI       = 1'b0;
        CPHA       = 1'b0;
        tx_data    = 8'h00;
        tx_valid   = 1'b0;
        rx_ack     = 1'b0;

        // Reset state
        tick(3);
        check_val("rst_miso", MISO, 0);
        check_val("rst_idle", idle, 1);
        check_val("rst_tx_ready", tx_ready, 1);
        check_val("rst_rx_data", rx_data, 0);
        check_val("rst_rx_valid", rx_valid, 0);
        check_val("rst_overrun", overrun, 0);
        check_val("rst_underrun", underrun, 0);
        rst = 1'b0;
        tick(2);

        // CPHA=0 frame: TX 0xA5, MOSI 0x3C
        write_tx(8'hA5);
        check_val("t1_tx_ready_full", tx_ready, 0);
        frame_start(1'b0);
        check_val("t1_idle_active", idle, 0);
        check_val("t1_tx_ready_moved", tx_ready, 1);
        xfer(1'b0, 8'h3C, 8, mi);
        check_val("t1_miso_word", mi, 8'hA5);
        check_val("t1_rx_data", rx_data, 8'h3C);
        check_val("t1_rx_valid", rx_valid, 1);
        frame_end();
        check_val("t1_idle_back", idle, 1);
        check_val("t1_miso_idle", MISO, 0);

        // CPHA=1 frame: TX 0x81, MOSI 0xFF
        ack_rx();
        check_val("t2_rx_valid_acked", rx_valid, 0);
        write_tx(8'h81);
        frame_start(1'b1);
        check_val("t2_miso_before_shift", MISO, 0);
        xfer(1'b1, 8'hFF, 8, mi);
        check_val("t2_miso_word", mi, 8'h81);
        check_val("t2_rx_data", rx_data, 8'hFF);
        check_val("t2_overrun", overrun, 0);
        frame_end();

        // Two back-to-back words, no rx_ack
        do_reset();
        write_tx(8'h12);
        frame_start(1'b0);
        check_val("t3_tx_ready_reopen", tx_ready, 1);
        write_tx(8'h34);
        xfer(1'b0, 8'h5A, 8, mi);
        check_val("t3_miso_word0", mi, 8'h12);
        check_val("t3_rx_word0", rx_data, 8'h5A);
        check_val("t3_overrun_word0", overrun, 0);
        xfer(1'b0, 8'hC3, 8, mi);
        check_val("t3_miso_word1", mi, 8'h34);
        check_val("t3_rx_word1", rx_data, 8'hC3);
        check_val("t3_overrun", overrun, 1);
        check_val("t3_rx_valid", rx_valid, 1);
        frame_end();

        // Frame with no TX written
        do_reset();
        frame_start(1'b0);
        check_val("t4_underrun", underrun, 1);
        xfer(1'b0, 8'h96, 8, mi);
        check_val("t4_miso_fill", mi, 8'h00);
        check_val("t4_tx_ready", tx_ready, 1);
        check_val("t4_rx_data", rx_data, 8'h96);
        frame_end();
        ack_rx();
        check_val("t4_rx_valid_acked", rx_valid, 0);
        check_val("t4_overrun", overrun, 0);

        // Aborted frame after 5 sample edges, then a full frame
        write_tx(8'hE7);
        frame_start(1'b0);
        xfer(1'b0, 8'hFF, 5, mi);
        check_val("t5_partial_miso", mi, 8'h1C);
        frame_end();
        check_val("t5_rx_valid_partial", rx_valid, 0);
        check_val("t5_rx_data_kept", rx_data, 8'h96);
        frame_start(1'b0);
        xfer(1'b0, 8'h5B, 8, mi);
        check_val("t5_miso_not_replayed", mi, 8'h00);
        check_val("t5_rx_data_full", rx_data, 8'h5B);
        check_val("t5_rx_valid_full", rx_valid, 1);
        frame_end();

        // Asynchronous reset mid-frame
        write_tx(8'hFF);
        frame_start(1'b0);
        xfer(1'b0, 8'h00, 3, mi);
        check_val("t6_pre_miso", MISO, 1);
        check_val("t6_pre_idle", idle, 0);
        @(negedge clk);
        #1 rst = 1'b1;
        #1;
        check_val("t6_miso", MISO, 0);
        check_val("t6_idle", idle, 1);
        check_val("t6_tx_ready", tx_ready, 1);
        check_val("t6_rx_data", rx_data, 0);
        check_val("t6_rx_valid", rx_valid, 0);
        check_val("t6_overrun", overrun, 0);
        check_val("t6_underrun", underrun, 0);
        SS_n = 1'b1;
        tick(3);
        rst = 1'b0;
        tick(2);

        $display("Simulation finished: %0d checks, %0d errors", chk_cnt, err_cnt);
        $finish;
    end

endmodule

// File: doc/spi_slave_shifter.md
Name: spi_slave_shifter

Overview:
- Data-path stage directly downstream of the slave SCK control block.
- Consumes its Shift_clk and Sample_clk strobes and the external SS_n/MOSI pins. All of these are asynchronous to the system clock.
- Deserialises MOSI into words and serialises transmit words onto MISO.
- Drives the idle input of the SCK control block.
- Offers a one-entry TX holding buffer and an RX output register to the register/bus side, both in the single clk domain.

Parameters:
- DATA_W, 8, word length in bits; legal range 4..32.
- TX_FILL, 0, DATA_W-bit word transmitted when the TX buffer is empty at word load.

Ports:
- clk  in  1  system clock; must be at least 8x SCK frequency.
- rst  in  1  asynchronous, active-high reset.
- Shift_clk  in  1  shift strobe level from SCK control; async.
- Sample_clk  in  1  sample strobe level from SCK control; async.
- SS_n  in  1  slave select, active low; async.
- MOSI  in  1  serial data in; async.
- CPHA  in  1  clock phase; static while SS_n is low.
- MISO  out  1  serial data out, MSB first.
- idle  out  1  high when no frame is active; to SCK control.
- tx_data  in  DATA_W  word to transmit.
- tx_valid  in  1  tx_data valid.
- tx_ready  out  1  TX holding buffer empty.
- rx_data  out  DATA_W  last complete received word.
- rx_valid  out  1  rx_data holds an unread word.
- rx_ack  in  1  consumer has read rx_data.
- overrun  out  1  sticky: a word completed while rx_valid was high.
- underrun  out  1  sticky: TX_FILL was sent because the buffer was empty.

Behaviour:
- Synchronisers:
  - Shift_clk, Sample_clk, SS_n and MOSI each pass through a 2-FF synchroniser.
  - A rising-edge detect on the synchronised Shift_clk gives sh_ev; on Sample_clk gives sa_ev. Each is a one-clk pulse.
  - The MOSI synchroniser has the same depth, so the MOSI value is aligned with sa_ev.
- Reset values: MISO=0, idle=1, tx_ready=1, rx_data=0, rx_valid=0, overrun=0, underrun=0. Shift registers, bit counter and state are cleared. Synchronisers are reset with SS_n stages set to 1 and all others to 0.
- TX buffer handshake:
  - Transfer occurs on a clk edge with tx_valid & tx_ready.
  - tx_ready drops the next cycle and rises again the cycle after the buffer is moved into the TX shifter.
- State machine:
  - IDLE:
    - idle=1, MISO=0, events ignored.
    - On synchronised SS_n falling: load the TX shifter from the buffer (or TX_FILL, setting underrun), set bit counter to 0, go to ACTIVE.
    - If CPHA=0, MISO presents the shifter MSB from the cycle after entry.
    - If CPHA=1, MISO stays 0 and the first_shift flag is set.
  - ACTIVE:
    - idle=0.
    - sa_ev: shift MOSI into the RX shifter LSB, counter+1.
    - sh_ev with first_shift set: clear first_shift and present the MSB. No shift occurs.
    - sh_ev otherwise: TX shifter shifts left one bit and MISO takes the new MSB.
    - When the counter reaches DATA_W on sa_ev, in the same cycle:
      - Copy the RX word, including the just-sampled bit, to rx_data and set rx_valid.
      - If rx_valid was already high and rx_ack is not also high this cycle, set overrun.
      - Reset the counter to 0.
      - Reload the TX shifter from the buffer or TX_FILL.
      - If CPHA=1, set first_shift again.
      - If CPHA=0, the next sh_ev after the word boundary presents the reloaded MSB without shifting.
    - Synchronised SS_n rising: go to IDLE. Any partial RX word is discarded and rx_data is unchanged. A partially sent TX word is dropped, not replayed.
- rx_valid clears on rx_ack. If rx_ack coincides with a word completion, rx_valid stays 1 with the new data and no overrun is set.
- sh_ev and sa_ev in the same cycle: process sa_ev first, then sh_ev, both in that cycle.
- overrun and underrun clear only on rst.
- The counter is clog2(DATA_W+1) bits wide and never exceeds DATA_W.

Test Plan:
- DATA_W=8, CPHA=0, tx_data=0xA5 loaded, then a full 8-bit SS_n frame with MOSI=0x3C -> MISO bits 1,0,1,0,0,1,0,1; rx_data=0x3C; rx_valid=1; idle returns to 1.
- CPHA=1, tx_data=0x81, MOSI=0xFF -> MISO stays 0 until the first Shift_clk, then sends 0x81; rx_data=0xFF.
- Two back-to-back words under one SS_n low with tx 0x12 then 0x34, and no rx_ack -> rx_data ends 0x(second MOSI word); overrun=1; MISO carries 0x12 then 0x34.
- Frame with no TX written -> MISO sends TX_FILL=0x00; underrun=1; tx_ready stays 1.
- SS_n rises after 5 sample edges -> rx_valid stays 0; rx_data is unchanged; a following full frame receives correctly.
- rst asserted mid-frame -> all outputs go to reset values immediately, without waiting for a clk edge.
